// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative M-extension multiply/divide unit.
// funct3 op encodings, op classification helpers and the FSM state type.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  function automatic logic is_div(input op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_rem(input op_e op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  function automatic logic a_signed(input op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic b_signed(input op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

  function automatic logic want_high(input op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_MULHU};
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Unsigned radix-2 datapath: shift/add multiply (mode=0) or restoring divide (mode=1).
// One shared XLEN+1-bit adder/subtractor; operands are loaded as magnitudes.
module muldiv_core #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                en,
  input  logic                mode,
  input  logic [XLEN-1:0]     load_lo,
  input  logic [XLEN-1:0]     load_m,
  output logic [2*XLEN-1:0]   acc,
  output logic                last
);

  logic [2*XLEN:0]  acc_q, acc_d;
  logic [XLEN-1:0]  m_q, m_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN:0]    op1, sum;
  logic [XLEN+1:0]  addsub;
  logic             take;

  assign last = (cnt_q == CNT_W'(XLEN - 1));
  assign acc  = acc_q[2*XLEN-1:0];

  always_comb begin
    // Divide looks at the upper bits as they will be after the left shift.
    op1    = mode ? acc_q[2*XLEN-1:XLEN-1] : acc_q[2*XLEN:XLEN];
    addsub = {1'b0, op1} + {1'b0, (mode ? ~{1'b0, m_q} : {1'b0, m_q})}
             + {{(XLEN+1){1'b0}}, mode};
    take   = mode ? addsub[XLEN+1] : acc_q[0];
    sum    = take ? addsub[XLEN:0] : op1;
    acc_d  = acc_q;
    m_d    = m_q;
    cnt_d  = cnt_q;
    if (load) begin
      acc_d = {{(XLEN+1){1'b0}}, load_lo};
      m_d   = load_m;
      cnt_d = '0;
    end else if (en) begin
      if (mode) acc_d = {sum, acc_q[XLEN-2:0], take};
      else      acc_d = {1'b0, sum, acc_q[XLEN-1:1]};
      if (!last) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      m_q   <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      m_q   <= m_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: FSM, sign conditioning,
// divide special-case fast path and final sign fix / result select.
module muldiv_unit import muldiv_pkg::*; #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] in_A,
  input  logic [XLEN-1:0] in_B,
  input  logic            flush,
  output logic            busy,
  output logic            ready,
  output logic [XLEN-1:0] out
);

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  op_e               op_q, op_d, op_in;
  logic              busy_q, busy_d, ready_q, ready_d;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic [XLEN-1:0]   out_q, out_d;
  logic              a_neg, b_neg, special, accept, core_en, core_last;
  logic [XLEN-1:0]   a_mag, b_mag, spec_res, fix_res, quo_s, rem_s;
  logic [2*XLEN-1:0] acc, prod_s;

  always_comb begin
    op_in   = op_e'(op);
    a_neg   = a_signed(op_in) && in_A[XLEN-1];
    b_neg   = b_signed(op_in) && in_B[XLEN-1];
    a_mag   = a_neg ? -in_A : in_A;
    b_mag   = b_neg ? -in_B : in_B;
    special = is_div(op_in) && ((in_B == '0) ||
              (a_signed(op_in) && (in_A == MOST_NEG) && (in_B == '1)));
    if (in_B == '0) spec_res = is_rem(op_in) ? in_A : '1;
    else            spec_res = is_rem(op_in) ? '0 : in_A;
    accept  = (state_q == IDLE) && valid && !flush;
    core_en = (state_q == CALC) && !flush;
  end

  muldiv_core #(.XLEN(XLEN), .CNT_W(CNT_W)) u_core (
    .clk     (clk),
    .rst     (rst),
    .load    (accept && !special),
    .en      (core_en),
    .mode    (is_div(op_q)),
    .load_lo (is_div(op_in) ? a_mag : b_mag),
    .load_m  (is_div(op_in) ? b_mag : a_mag),
    .acc     (acc),
    .last    (core_last)
  );

  // Remainder takes the dividend's sign; quotient and product take sA^sB.
  always_comb begin
    prod_s = (sa_q ^ sb_q) ? -acc : acc;
    quo_s  = (sa_q ^ sb_q) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_s  = sa_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (is_div(op_q)) fix_res = is_rem(op_q) ? rem_s : quo_s;
    else              fix_res = want_high(op_q) ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    case (state_q)
      IDLE: if (accept) begin
        op_d = op_in;
        sa_d = a_neg;
        sb_d = b_neg;
        if (special) begin
          state_d = DONE;
          out_d   = spec_res;
        end else begin
          state_d = CALC;
        end
      end
      CALC: if (flush) state_d = IDLE;
            else if (core_last) state_d = FIX;
      FIX:  if (flush) state_d = IDLE;
            else begin
              state_d = DONE;
              out_d   = fix_res;
            end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d == CALC) || (state_d == FIX);
    ready_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      out_q   <= '0;
      op_q    <= OP_MUL;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      out_q   <= out_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
    end
  end

  assign busy  = busy_q;
  assign ready = ready_q;
  assign out   = out_q;

endmodule
